// File: rtl/game2048_pkg.sv
// Shared types for the 2048 move engine: FSM states, move directions,
// spawn LFSR taps and the line-to-cell mapping used by both the engine and its users.
package game2048_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINE,
        ST_SPAWN,
        ST_CHECK,
        ST_INIT
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Cell index (4*y+x) of position k along a line, where k = 0 is the destination wall
    function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] line,
                                            input logic [1:0] k);
        case (dir)
            DIR_UP:   return {k, line};
            DIR_DOWN: return {~k, line};
            DIR_LEFT: return {line, k};
            default:  return {line, ~k};
        endcase
    endfunction

endpackage

// File: rtl/line_merge_2048.sv
// One 2048 line: compact toward the wall (cell 0), then merge equal pairs starting
// at the wall, each tile merging at most once. Purely combinational.
module line_merge_2048 (
    input  logic [15:0] line_i,
    output logic [15:0] line_o,
    output logic        changed_o,
    output logic [23:0] score_inc_o
);

    logic [3:0] packed_c [5];

    function automatic logic [3:0] sat_inc(input logic [3:0] e);
        return (e == 4'd15) ? 4'd15 : e + 4'd1;
    endfunction

    always_comb begin
        logic [2:0] n;
        logic [2:0] o;
        logic       skip;
        for (int i = 0; i < 5; i++) packed_c[i] = '0;
        line_o      = '0;
        score_inc_o = '0;
        n           = '0;
        o           = '0;
        skip        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (line_i[4*i +: 4] != 4'd0) begin
                packed_c[n] = line_i[4*i +: 4];
                n           = n + 3'd1;
            end
        end
        // packed_c[4] is always zero, so the last cell never finds a partner
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_c[i] != 4'd0) begin
                if (packed_c[i] == packed_c[i+1]) begin
                    line_o[{o[1:0], 2'b00} +: 4] = sat_inc(packed_c[i]);
                    score_inc_o = score_inc_o + (24'd1 << ({1'b0, packed_c[i]} + 5'd1));
                    skip = 1'b1;
                end else begin
                    line_o[{o[1:0], 2'b00} +: 4] = packed_c[i];
                end
                o = o + 3'd1;
            end
        end
        changed_o = (line_o != line_i);
    end

endmodule

// File: rtl/move_engine_2048.sv
// 2048 game engine: edge-detected buttons drive a move FSM that slides one line per
// cycle, spawns a tile from an LFSR-chosen empty cell, then re-evaluates win/game-over.
module move_engine_2048 #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          WIN_EXP = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        load_en,
    input  logic [63:0] load_grid,
    output logic [63:0] grid_flat,
    output logic [23:0] score,
    output logic        busy,
    output logic        won,
    output logic        game_over
);

    import game2048_pkg::*;

    state_e      state_q;
    dir_e        dir_q;
    logic [1:0]  line_q;
    logic        moved_q;
    logic        spawn_first_q;
    logic        spawns_left_q;
    logic [3:0]  scan_idx_q;
    logic [3:0]  scan_cnt_q;
    logic        boot_q;
    logic [4:0]  prev_q;
    logic [15:0] lfsr_q;
    logic [63:0] grid_q;
    logic [23:0] score_q;
    logic        won_q;
    logic        game_over_q;
    logic        busy_q;

    logic [4:0]  btn_now;
    logic [4:0]  press;
    logic [15:0] line_in;
    logic [15:0] line_out;
    logic        line_changed;
    logic [23:0] line_score;
    logic [3:0]  scan_cell;
    logic        any_win;
    logic        any_empty;
    logic        any_pair;

    function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [23:0] b);
        logic [24:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[24] ? 24'hFFFFFF : s[23:0];
    endfunction

    assign btn_now   = {btn_start, btn_right, btn_left, btn_down, btn_up};
    assign press     = btn_now & ~prev_q;
    assign scan_cell = grid_q[{scan_idx_q, 2'b00} +: 4];

    always_comb begin
        line_in = '0;
        for (int k = 0; k < 4; k++)
            line_in[4*k +: 4] = grid_q[{cell_idx(dir_q, line_q, 2'(k)), 2'b00} +: 4];
    end

    line_merge_2048 u_line (
        .line_i      (line_in),
        .line_o      (line_out),
        .changed_o   (line_changed),
        .score_inc_o (line_score)
    );

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (int'(grid_q[4*i +: 4]) >= WIN_EXP) any_win = 1'b1;
            if (grid_q[4*i +: 4] == 4'd0) any_empty = 1'b1;
        end
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 3; x++)
                if (grid_q[16*y + 4*x +: 4] == grid_q[16*y + 4*x + 4 +: 4]) any_pair = 1'b1;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                if (grid_q[16*y + 4*x +: 4] == grid_q[16*y + 4*x + 16 +: 4]) any_pair = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dir_q         <= DIR_UP;
            line_q        <= '0;
            moved_q       <= 1'b0;
            spawn_first_q <= 1'b0;
            spawns_left_q <= 1'b0;
            scan_idx_q    <= '0;
            scan_cnt_q    <= '0;
            boot_q        <= 1'b1;
            prev_q        <= '1;
            grid_q        <= '0;
            score_q       <= '0;
            won_q         <= 1'b0;
            game_over_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            prev_q <= btn_now;
            boot_q <= 1'b0;
            if (press[4]) begin
                grid_q      <= '0;
                score_q     <= '0;
                won_q       <= 1'b0;
                game_over_q <= 1'b0;
                state_q     <= ST_INIT;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (boot_q) begin
                            state_q <= ST_INIT;
                            busy_q  <= 1'b1;
                        end else if (load_en) begin
                            grid_q  <= load_grid;
                            state_q <= ST_CHECK;
                            busy_q  <= 1'b1;
                        end else if (!game_over_q && (press[3:0] != 4'd0)) begin
                            if (press[0])      dir_q <= DIR_UP;
                            else if (press[1]) dir_q <= DIR_DOWN;
                            else if (press[2]) dir_q <= DIR_LEFT;
                            else               dir_q <= DIR_RIGHT;
                            line_q  <= '0;
                            moved_q <= 1'b0;
                            state_q <= ST_LINE;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_LINE: begin
                        for (int k = 0; k < 4; k++)
                            grid_q[{cell_idx(dir_q, line_q, 2'(k)), 2'b00} +: 4] <= line_out[4*k +: 4];
                        score_q <= sat_add(score_q, line_score);
                        moved_q <= moved_q | line_changed;
                        line_q  <= line_q + 2'd1;
                        if (line_q == 2'd3) begin
                            if (moved_q || line_changed) begin
                                state_q       <= ST_SPAWN;
                                spawn_first_q <= 1'b1;
                                spawns_left_q <= 1'b0;
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                    ST_SPAWN: begin
                        if (spawn_first_q) begin
                            scan_idx_q    <= lfsr_q[3:0];
                            scan_cnt_q    <= '0;
                            spawn_first_q <= 1'b0;
                        end else if (scan_cell == 4'd0 || scan_cnt_q == 4'd15) begin
                            if (scan_cell == 4'd0)
                                grid_q[{scan_idx_q, 2'b00} +: 4] <= (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
                            if (spawns_left_q) begin
                                spawns_left_q <= 1'b0;
                                spawn_first_q <= 1'b1;
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end else begin
                            scan_idx_q <= scan_idx_q + 4'd1;
                            scan_cnt_q <= scan_cnt_q + 4'd1;
                        end
                    end
                    ST_INIT: begin
                        state_q       <= ST_SPAWN;
                        spawn_first_q <= 1'b1;
                        spawns_left_q <= 1'b1;
                    end
                    ST_CHECK: begin
                        won_q       <= won_q | any_win;
                        game_over_q <= !any_empty && !any_pair;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign grid_flat = grid_q;
    assign score     = score_q;
    assign busy      = busy_q;
    assign won       = won_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_move_engine_2048.sv
// Bench for move_engine_2048: a queue of expected results is filled as stimulus is
// issued and drained by a monitor at each busy falling edge.
module tb_move_engine_2048;

    logic        clk, rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_start;
    logic        load_en;
    logic [63:0] load_grid;
    logic [63:0] grid_flat;
    logic [23:0] score;
    logic        busy, won, game_over;

    move_engine_2048 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_start (btn_start),
        .load_en   (load_en),
        .load_grid (load_grid),
        .grid_flat (grid_flat),
        .score     (score),
        .busy      (busy),
        .won       (won),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_INIT = 0, K_LOAD = 1, K_MOVE = 2;

    typedef struct {
        int          kind;
        logic [63:0] grid;
        logic [23:0] score;
        bit          won;
        bit          go;
        bit          moved;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] board_m;
    logic [23:0] score_m;
    bit          won_m, go_m;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic bit has_win(input logic [63:0] b);
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] >= 4'd11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_over(input logic [63:0] b);
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] == 4'd0) return 1'b0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                if (x < 3 && b[4*(4*y+x) +: 4] == b[4*(4*y+x+1) +: 4]) return 1'b0;
                if (y < 3 && b[4*(4*y+x) +: 4] == b[4*(4*y+x+4) +: 4]) return 1'b0;
            end
        return 1'b1;
    endfunction

    // Reference move: gather each line from the wall outward, drop blanks, merge pairs from the front
    task automatic model_move(input logic [63:0] b, input int dir, output logic [63:0] nb,
                              output int inc, output bit moved);
        int vals[$];
        int res[$];
        int pos[4];
        int a, x, y;
        nb  = b;
        inc = 0;
        for (int line = 0; line < 4; line++) begin
            vals.delete();
            res.delete();
            for (int k = 0; k < 4; k++) begin
                case (dir)
                    0: begin x = line;  y = k;     end
                    1: begin x = line;  y = 3 - k; end
                    2: begin x = k;     y = line;  end
                    default: begin x = 3 - k; y = line; end
                endcase
                pos[k] = 4*y + x;
                if (b[4*pos[k] +: 4] != 4'd0) vals.push_back(int'(b[4*pos[k] +: 4]));
            end
            while (vals.size() > 0) begin
                a = vals.pop_front();
                if (vals.size() > 0 && vals[0] == a) begin
                    void'(vals.pop_front());
                    res.push_back((a == 15) ? 15 : a + 1);
                    inc += 2 ** (a + 1);
                end else begin
                    res.push_back(a);
                end
            end
            for (int k = 0; k < 4; k++)
                nb[4*pos[k] +: 4] = (k < res.size()) ? 4'(res[k]) : 4'd0;
        end
        moved = (nb != b);
    endtask

    // Monitor: one expected entry per busy falling edge
    initial begin
        bit   busy_prev;
        int   bcyc;
        int   nz, bad, nd;
        exp_t e;
        busy_prev = 1'b0;
        bcyc      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev = 1'b0;
                bcyc      = 0;
            end else begin
                if (busy) bcyc++;
                if (busy_prev && !busy) begin
                    if (q.size() == 0) begin
                        cmp("unexpected_done", 64'(bcyc), 64'd0);
                    end else begin
                        e = q.pop_front();
                        cmp("won", 64'(won), 64'(e.won));
                        if (e.kind == K_INIT) begin
                            nz  = 0;
                            bad = 0;
                            for (int i = 0; i < 16; i++) begin
                                if (grid_flat[4*i +: 4] != 4'd0) nz++;
                                if (grid_flat[4*i +: 4] > 4'd2) bad++;
                            end
                            cmp("init_tiles", 64'(nz), 64'd2);
                            cmp("init_vals", 64'(bad), 64'd0);
                            cmp("init_score", 64'(score), 64'd0);
                            cmp("init_over", 64'(game_over), 64'd0);
                        end else begin
                            cmp("score", 64'(score), 64'(e.score));
                            if (e.kind == K_LOAD || !e.moved) begin
                                cmp("grid", grid_flat, e.grid);
                                cmp("over", 64'(game_over), 64'(e.go));
                                if (e.kind == K_MOVE) cmp("nomove_busy", 64'(bcyc), 64'd5);
                            end else begin
                                nd  = 0;
                                bad = 0;
                                for (int i = 0; i < 16; i++)
                                    if (grid_flat[4*i +: 4] != e.grid[4*i +: 4]) begin
                                        nd++;
                                        if (e.grid[4*i +: 4] != 4'd0 || grid_flat[4*i +: 4] > 4'd2 ||
                                            grid_flat[4*i +: 4] == 4'd0) bad++;
                                    end
                                cmp("spawn_count", 64'(nd), 64'd1);
                                cmp("spawn_cell", 64'(bad), 64'd0);
                                cmp("over_spawn", 64'(game_over), 64'(is_over(grid_flat)));
                            end
                        end
                    end
                    bcyc = 0;
                end
                busy_prev = busy;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            cmp("timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        {btn_start, btn_right, btn_left, btn_down, btn_up} = m;
        @(negedge clk);
        {btn_start, btn_right, btn_left, btn_down, btn_up} = '0;
    endtask

    task automatic do_load(input logic [63:0] b);
        exp_t e;
        board_m = b;
        won_m   = won_m | has_win(b);
        go_m    = is_over(b);
        e = '{kind: K_LOAD, grid: b, score: score_m, won: won_m, go: go_m, moved: 1'b0};
        q.push_back(e);
        @(negedge clk);
        load_en   = 1'b1;
        load_grid = b;
        @(negedge clk);
        load_en = 1'b0;
        wait_idle();
    endtask

    task automatic do_move(input logic [3:0] m, input bit extra);
        exp_t        e;
        logic [63:0] nb;
        int          inc, d;
        bit          mv;
        longint      s;
        if (go_m) begin
            pulse({1'b0, m});
            repeat (8) @(negedge clk);
            cmp("ignored_grid", grid_flat, board_m);
            cmp("ignored_busy", 64'(busy), 64'd0);
            return;
        end
        d = 3;
        for (int i = 3; i >= 0; i--) if (m[i]) d = i;
        model_move(board_m, d, nb, inc, mv);
        s       = longint'(score_m) + longint'(inc);
        score_m = (s > 64'hFFFFFF) ? 24'hFFFFFF : 24'(s);
        won_m   = won_m | has_win(nb);
        e = '{kind: K_MOVE, grid: nb, score: score_m, won: won_m, go: is_over(nb), moved: mv};
        q.push_back(e);
        pulse({1'b0, m});
        if (extra) pulse(5'b00010);
        wait_idle();
    endtask

    task automatic do_start();
        exp_t e;
        score_m = '0;
        won_m   = 1'b0;
        go_m    = 1'b0;
        e = '{kind: K_INIT, grid: '0, score: '0, won: 1'b0, go: 1'b0, moved: 1'b0};
        q.push_back(e);
        pulse(5'b10000);
        wait_idle();
    endtask

    function automatic logic [63:0] rand_board(input bit full);
        logic [63:0] b;
        for (int i = 0; i < 16; i++) begin
            if (!full && $urandom_range(0, 9) < 4) b[4*i +: 4] = 4'd0;
            else b[4*i +: 4] = 4'($urandom_range(1, full ? 6 : 4));
        end
        if ($urandom_range(0, 9) == 0) b[7:0] = 8'hAA;
        return b;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [23:0] s0;
        logic [3:0]  m;
        {btn_start, btn_right, btn_left, btn_down, btn_up} = '0;
        load_en   = 1'b0;
        load_grid = '0;
        score_m   = '0;
        won_m     = 1'b0;
        go_m      = 1'b0;
        board_m   = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_grid", grid_flat, 64'd0);
        cmp("rst_score", 64'(score), 64'd0);
        cmp("rst_busy", 64'(busy), 64'd0);
        cmp("rst_won", 64'(won), 64'd0);
        cmp("rst_over", 64'(game_over), 64'd0);
        e = '{kind: K_INIT, grid: '0, score: '0, won: 1'b0, go: 1'b0, moved: 1'b0};
        q.push_back(e);
        rst_n = 1'b1;
        wait_idle();

        // Directed boards
        do_load(64'h0000_0000_0000_1111);
        s0 = score;
        do_move(4'b0100, 1'b0);
        cmp("r034_row0", 64'(grid_flat[7:0]), 64'h22);
        cmp("r034_score", 64'(score - s0), 64'd8);
        do_load(64'h0000_0000_0000_0112);
        s0 = score;
        do_move(4'b0100, 1'b0);
        cmp("r035_row0", 64'(grid_flat[7:0]), 64'h22);
        cmp("r035_score", 64'(score - s0), 64'd4);
        do_load(64'h0000_0012_8765_4321);
        do_move(4'b0100, 1'b0);
        do_load(64'h1212_2121_1212_2121);
        cmp("r037_over", 64'(game_over), 64'd1);
        do_move(4'b0001, 1'b0);
        do_start();
        do_load(64'h0000_0000_0000_00AA);
        s0 = score;
        do_move(4'b0100, 1'b1);
        cmp("r038_cell", 64'(grid_flat[3:0]), 64'd11);
        cmp("r038_won", 64'(won), 64'd1);
        cmp("r038_score", 64'(score - s0), 64'd2048);

        // Reset in the middle of a move
        do_load(64'h0000_0000_0000_1111);
        pulse(5'b00100);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_grid", grid_flat, 64'd0);
        cmp("midrst_score", 64'(score), 64'd0);
        cmp("midrst_busy", 64'(busy), 64'd0);
        cmp("midrst_won", 64'(won), 64'd0);
        cmp("midrst_over", 64'(game_over), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        score_m = '0;
        won_m   = 1'b0;
        go_m    = 1'b0;
        e = '{kind: K_INIT, grid: '0, score: '0, won: 1'b0, go: 1'b0, moved: 1'b0};
        q.push_back(e);
        rst_n = 1'b1;
        wait_idle();

        // Randomized boards and directions
        for (int it = 0; it < 60; it++) begin
            do_load(rand_board(it % 7 == 0));
            if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(1, 15));
            else m = 4'd1 << $urandom_range(0, 3);
            do_move(m, $urandom_range(0, 4) == 0);
        end
        do_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
